// File: rtl/mips_defs.sv
// Shared definitions for the MIPS run controller.
//  - status_e   : run-controller state / status encoding (also driven on the status port)
//  - DEF_*      : default completion-signature address and pass value
//  - is_done()  : true for the sticky completion states
package mips_defs;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PAUSED  = 3'd2,
        ST_PASS    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_TIMEOUT = 3'd5
    } status_e;

    localparam logic [31:0] DEF_TOHOST_ADDR = 32'hFFFF_FFF0;
    localparam logic [31:0] DEF_PASS_VALUE  = 32'h0000_0001;

    function automatic logic is_done(input status_e st);
        return (st == ST_PASS) || (st == ST_FAIL) || (st == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser and debouncer.
//  CLOCK_50 in  system clock
//  reset    in  asynchronous active-low reset
//  btn_n    in  raw button, pressed = 0
//  level_n  out debounced level, pressed = 0 (released after reset)
//  press    out one-cycle pulse on the debounced 1->0 edge
// The debounced level only follows the synchronised input once it has
// differed from the current level for DEBOUNCE consecutive samples.
module btn_debounce #(
    parameter int unsigned DEBOUNCE = 250000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic btn_n,
    output logic level_n,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            stable_cnt <= '0;
            level_n    <= 1'b1;
            press      <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level_n) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DEBOUNCE - 1)) begin
                // DEBOUNCE-th consecutive differing sample: accept new level
                stable_cnt <= '0;
                level_n    <= sync2;
                press      <= level_n & ~sync2;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller between board inputs and the MIPS core.
// Holds the core in reset for RESET_HOLD cycles, runs it under a budget of
// MAX_CYCLES enabled cycles, and ends the run on a write to TOHOST_ADDR
// (PASS if the data equals PASS_VALUE, FAIL otherwise) or on TIMEOUT.
// Debounced restart (any state -> HOLD) and pause (RUN <-> PAUSED) buttons.
//  CLOCK_50      in  system clock
//  reset         in  asynchronous active-low reset
//  btn_restart_n in  raw restart button, pressed = 0
//  btn_pause_n   in  raw pause button, pressed = 0
//  mem_we        in  core data-memory write strobe
//  mem_addr      in  core data-memory address
//  mem_wdata     in  core data-memory write data
//  core_reset_n  out registered active-low reset to the core
//  core_en       out core clock-enable
//  status        out 0 HOLD, 1 RUN, 2 PAUSED, 3 PASS, 4 FAIL, 5 TIMEOUT
//  done          out high in PASS/FAIL/TIMEOUT
//  cycle_count   out enabled RUN cycles since last HOLD exit
//  result_data   out signature value captured at completion
module mips_run_ctrl
    import mips_defs::*;
#(
    parameter int unsigned          ADDR_W      = 32,
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          CNT_W       = 32,
    parameter int unsigned          RESET_HOLD  = 26,
    parameter int unsigned          MAX_CYCLES  = 500000,
    parameter logic [ADDR_W-1:0]    TOHOST_ADDR = ADDR_W'(DEF_TOHOST_ADDR),
    parameter logic [DATA_W-1:0]    PASS_VALUE  = DATA_W'(DEF_PASS_VALUE),
    parameter int unsigned          DEBOUNCE    = 250000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              btn_restart_n,
    input  logic              btn_pause_n,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              core_reset_n,
    output logic              core_en,
    output logic [2:0]        status,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [DATA_W-1:0] result_data
);

    localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    status_e           state;
    status_e           next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              restart_press;
    logic              pause_press;
    logic              restart_level_unused;
    logic              pause_level_unused;
    logic              tohost_hit;
    logic              hold_last;
    logic              budget_last;
    logic              budget_full;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_restart_db (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .btn_n    (btn_restart_n),
        .level_n  (restart_level_unused),
        .press    (restart_press)
    );

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_pause_db (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .btn_n    (btn_pause_n),
        .level_n  (pause_level_unused),
        .press    (pause_press)
    );

    assign tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR);
    assign hold_last   = (hold_cnt == HOLD_W'(RESET_HOLD - 1));
    assign budget_last = (cycle_count == CNT_W'(MAX_CYCLES - 1));
    assign budget_full = (cycle_count == CNT_W'(MAX_CYCLES));

    // Priority: restart > tohost completion > budget end > pause
    always_comb begin
        next_state = state;
        case (state)
            ST_HOLD: begin
                if (hold_last) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (tohost_hit)
                    next_state = (mem_wdata == PASS_VALUE) ? ST_PASS : ST_FAIL;
                else if (budget_last)
                    next_state = ST_TIMEOUT;
                else if (pause_press)
                    next_state = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (pause_press) next_state = ST_RUN;
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: next_state = state;
            default: next_state = ST_HOLD;
        endcase
        if (restart_press) next_state = ST_HOLD;
    end

    // Outputs are registered from next_state so they line up with status.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state        <= ST_HOLD;
            core_reset_n <= 1'b0;
            core_en      <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= next_state;
            core_reset_n <= (next_state != ST_HOLD);
            core_en      <= (next_state == ST_RUN);
            done         <= is_done(next_state);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (state == ST_HOLD && next_state == ST_HOLD && !restart_press) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end else begin
            hold_cnt <= '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            result_data <= '0;
        end else if (next_state == ST_HOLD) begin
            cycle_count <= '0;
            result_data <= '0;
        end else begin
            if (state == ST_RUN && !budget_full)
                cycle_count <= cycle_count + CNT_W'(1);
            if (state == ST_RUN && (next_state == ST_PASS || next_state == ST_FAIL))
                result_data <= mem_wdata;
        end
    end

    assign status = state;

endmodule

// File: tb/tb_mips_run_ctrl.sv
module tb_mips_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_restart_n = 1'b1;
    logic        btn_pause_n = 1'b1;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        core_reset_n;
    logic        core_en;
    logic [2:0]  status;
    logic        done;
    logic [31:0] cycle_count;
    logic [31:0] result_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mips_run_ctrl #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .CNT_W       (32),
        .RESET_HOLD  (4),
        .MAX_CYCLES  (100),
        .TOHOST_ADDR (32'hFFFF_FFF0),
        .PASS_VALUE  (32'h1),
        .DEBOUNCE    (3)
    ) dut (
        .CLOCK_50      (clk),
        .reset         (rst_n),
        .btn_restart_n (btn_restart_n),
        .btn_pause_n   (btn_pause_n),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .core_reset_n  (core_reset_n),
        .core_en       (core_en),
        .status        (status),
        .done          (done),
        .cycle_count   (cycle_count),
        .result_data   (result_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset, release, and wait out the 4-cycle hold; leaves DUT in RUN with count 0.
    task automatic reset_and_run();
        mem_we = 1'b0;
        btn_restart_n = 1'b1;
        btn_pause_n = 1'b1;
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        ticks(4);
    endtask

    task automatic write_mem(input logic [31:0] addr, input logic [31:0] data);
        mem_we = 1'b1;
        mem_addr = addr;
        mem_wdata = data;
        tick();
        mem_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ticks(5);
        tests++; if (status !== 3'd0) begin fails++; $display("FAIL rst_status: got %0d expected 0", status); end
        tests++; if ({core_reset_n, core_en, done} !== 3'b000) begin fails++; $display("FAIL rst_ctrl: got %b expected 000", {core_reset_n, core_en, done}); end
        tests++; if (cycle_count !== 32'd0 || result_data !== 32'd0) begin fails++; $display("FAIL rst_regs: got %0d/%h expected 0/0", cycle_count, result_data); end
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests++; if (core_reset_n !== 1'b0 || status !== 3'd0) begin fails++; $display("FAIL hold_%0d: got rn=%b st=%0d expected rn=0 st=0", i, core_reset_n, status); end
        end
        tick();
        tests++; if ({core_reset_n, core_en, status} !== {1'b1, 1'b1, 3'd1}) begin fails++; $display("FAIL run_entry: got rn=%b en=%b st=%0d expected 1 1 1", core_reset_n, core_en, status); end
        tests++; if (cycle_count !== 32'd0) begin fails++; $display("FAIL run_count0: got %0d expected 0", cycle_count); end
        ticks(2);
        tests++; if (cycle_count !== 32'd2) begin fails++; $display("FAIL run_count2: got %0d expected 2", cycle_count); end
    endtask

    task automatic test_pass();
        reset_and_run();
        ticks(20);
        write_mem(32'hFFFF_FFF0, 32'h1);
        tests++; if (status !== 3'd3 || done !== 1'b1) begin fails++; $display("FAIL pass_status: got st=%0d done=%b expected 3 1", status, done); end
        tests++; if (result_data !== 32'h1) begin fails++; $display("FAIL pass_result: got %h expected 00000001", result_data); end
        tests++; if (core_en !== 1'b0 || core_reset_n !== 1'b1) begin fails++; $display("FAIL pass_core: got en=%b rn=%b expected 0 1", core_en, core_reset_n); end
        tests++; if (cycle_count !== 32'd21) begin fails++; $display("FAIL pass_count: got %0d expected 21", cycle_count); end
        ticks(5);
        tests++; if (status !== 3'd3 || cycle_count !== 32'd21) begin fails++; $display("FAIL pass_sticky: got st=%0d cnt=%0d expected 3 21", status, cycle_count); end
    endtask

    task automatic test_fail_and_wrong_addr();
        reset_and_run();
        ticks(5);
        write_mem(32'hFFFF_FFF4, 32'h1);
        tests++; if (status !== 3'd1 || result_data !== 32'd0) begin fails++; $display("FAIL wrong_addr: got st=%0d res=%h expected 1 0", status, result_data); end
        write_mem(32'hFFFF_FFF0, 32'hDEAD);
        tests++; if (status !== 3'd4 || done !== 1'b1) begin fails++; $display("FAIL fail_status: got st=%0d done=%b expected 4 1", status, done); end
        tests++; if (result_data !== 32'hDEAD) begin fails++; $display("FAIL fail_result: got %h expected 0000dead", result_data); end
        tests++; if (cycle_count !== 32'd7) begin fails++; $display("FAIL fail_count: got %0d expected 7", cycle_count); end
    endtask

    task automatic test_timeout();
        reset_and_run();
        ticks(99);
        tests++; if (status !== 3'd1 || cycle_count !== 32'd99) begin fails++; $display("FAIL to_before: got st=%0d cnt=%0d expected 1 99", status, cycle_count); end
        tick();
        tests++; if (status !== 3'd5 || done !== 1'b1 || core_en !== 1'b0) begin fails++; $display("FAIL to_status: got st=%0d done=%b en=%b expected 5 1 0", status, done, core_en); end
        tests++; if (cycle_count !== 32'd100) begin fails++; $display("FAIL to_count: got %0d expected 100", cycle_count); end
        ticks(3);
        tests++; if (cycle_count !== 32'd100 || status !== 3'd5) begin fails++; $display("FAIL to_sticky: got st=%0d cnt=%0d expected 5 100", status, cycle_count); end
    endtask

    task automatic test_budget_edge();
        reset_and_run();
        ticks(99);
        write_mem(32'hFFFF_FFF0, 32'h5);
        tests++; if (status !== 3'd4) begin fails++; $display("FAIL edge_status: got %0d expected 4", status); end
        tests++; if (result_data !== 32'h5 || cycle_count !== 32'd100) begin fails++; $display("FAIL edge_regs: got res=%h cnt=%0d expected 5 100", result_data, cycle_count); end
    endtask

    task automatic test_pause();
        reset_and_run();
        ticks(10);
        btn_pause_n = 1'b0;
        ticks(5);
        tests++; if (status !== 3'd1) begin fails++; $display("FAIL pause_latency: got %0d expected 1", status); end
        tick();
        tests++; if (status !== 3'd2 || core_en !== 1'b0 || core_reset_n !== 1'b1) begin fails++; $display("FAIL pause_enter: got st=%0d en=%b rn=%b expected 2 0 1", status, core_en, core_reset_n); end
        tests++; if (cycle_count !== 32'd16) begin fails++; $display("FAIL pause_count: got %0d expected 16", cycle_count); end
        btn_pause_n = 1'b1;
        ticks(3);
        write_mem(32'hFFFF_FFF0, 32'h1);
        ticks(6);
        tests++; if (status !== 3'd2 || result_data !== 32'd0) begin fails++; $display("FAIL pause_tohost: got st=%0d res=%h expected 2 0", status, result_data); end
        tests++; if (cycle_count !== 32'd16) begin fails++; $display("FAIL pause_hold: got %0d expected 16", cycle_count); end
        btn_pause_n = 1'b0;
        ticks(2);
        btn_pause_n = 1'b1;
        ticks(8);
        tests++; if (status !== 3'd2) begin fails++; $display("FAIL glitch: got %0d expected 2", status); end
        btn_pause_n = 1'b0;
        ticks(6);
        tests++; if (status !== 3'd1 || core_en !== 1'b1 || cycle_count !== 32'd16) begin fails++; $display("FAIL resume: got st=%0d en=%b cnt=%0d expected 1 1 16", status, core_en, cycle_count); end
        btn_pause_n = 1'b1;
        tick();
        tests++; if (cycle_count !== 32'd17) begin fails++; $display("FAIL resume_count: got %0d expected 17", cycle_count); end
    endtask

    task automatic test_restart();
        reset_and_run();
        ticks(3);
        write_mem(32'hFFFF_FFF0, 32'h1);
        btn_pause_n = 1'b0;
        ticks(8);
        btn_pause_n = 1'b1;
        tests++; if (status !== 3'd3) begin fails++; $display("FAIL pause_in_pass: got %0d expected 3", status); end
        btn_restart_n = 1'b0;
        ticks(5);
        tests++; if (status !== 3'd3) begin fails++; $display("FAIL restart_latency: got %0d expected 3", status); end
        tick();
        btn_restart_n = 1'b1;
        tests++; if (status !== 3'd0 || done !== 1'b0) begin fails++; $display("FAIL restart_status: got st=%0d done=%b expected 0 0", status, done); end
        tests++; if ({core_reset_n, core_en} !== 2'b00 || cycle_count !== 32'd0 || result_data !== 32'd0) begin fails++; $display("FAIL restart_regs: got rn/en=%b cnt=%0d res=%h expected 00 0 0", {core_reset_n, core_en}, cycle_count, result_data); end
        ticks(3);
        tests++; if (status !== 3'd0 || core_reset_n !== 1'b0) begin fails++; $display("FAIL restart_hold: got st=%0d rn=%b expected 0 0", status, core_reset_n); end
        tick();
        tests++; if (status !== 3'd1 || core_reset_n !== 1'b1 || cycle_count !== 32'd0) begin fails++; $display("FAIL restart_run: got st=%0d rn=%b cnt=%0d expected 1 1 0", status, core_reset_n, cycle_count); end
    endtask

    task automatic test_async_reset();
        reset_and_run();
        ticks(7);
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (status !== 3'd0 || {core_reset_n, core_en, done} !== 3'b000) begin fails++; $display("FAIL async_ctrl: got st=%0d rn/en/done=%b expected 0 000", status, {core_reset_n, core_en, done}); end
        tests++; if (cycle_count !== 32'd0 || result_data !== 32'd0) begin fails++; $display("FAIL async_regs: got cnt=%0d res=%h expected 0 0", cycle_count, result_data); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail_and_wrong_addr();
        test_timeout();
        test_budget_edge();
        test_pause();
        test_restart();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
